seven_seg_capture: RTL

//  Receive-side counterpart of the hex-to-segment display driver. Samples a time-multiplexed,

---
 rtl/seven_seg_capture.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_capture.sv
// ============================================================================
// Module   : seven_seg_capture
// Purpose  : Samples a multiplexed active-low 7-segment bus, decodes each
//            stable digit back to a hex nibble and hands out complete frames.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seven_seg_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic [4*DIGITS-1:0]   frame_data,
    output logic [DIGITS-1:0]     frame_err,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  overrun
);

    localparam int         c_IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_HELD  = 2'd2
    } state_t;

    logic [6:0]          r_seg_s1, r_seg_s2, r_seg_prev;
    logic [DIGITS-1:0]   r_an_s1, r_an_s2, r_an_prev;
    state_t              r_state, w_state_next;
    logic [CNT_W-1:0]    r_stab_cnt, w_stab_cnt_next;
    logic [DIGITS-1:0]   r_seen;
    logic [4*DIGITS-1:0] r_shadow_data;
    logic [DIGITS-1:0]   r_shadow_err;

    logic [DIGITS-1:0]   w_an_act;
    logic                w_an_onehot;
    logic                w_changed;
    logic                w_capture;
    logic [c_IDX_W-1:0]  w_digit_idx;
    logic [DIGITS-1:0]   w_we;
    logic [3:0]          w_nibble;
    logic                w_dec_err;
    logic                w_frame_done;

    // Two-flop synchronizer; idle bus (all segments and anodes off) is all ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg_s1   <= '1;
            r_seg_s2   <= '1;
            r_seg_prev <= '1;
            r_an_s1    <= '1;
            r_an_s2    <= '1;
            r_an_prev  <= '1;
        end else begin
            r_seg_s1   <= seg_in;
            r_seg_s2   <= r_seg_s1;
            r_seg_prev <= r_seg_s2;
            r_an_s1    <= an_in;
            r_an_s2    <= r_an_s1;
            r_an_prev  <= r_an_s2;
        end
    end

    assign w_an_act    = ~r_an_s2;
    assign w_an_onehot = (w_an_act != '0) && ((w_an_act & (w_an_act - 1'b1)) == '0);
    assign w_changed   = (r_an_s2 != r_an_prev) || (r_seg_s2 != r_seg_prev);

    always_comb begin
        w_digit_idx = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_an_act[k]) begin
                w_digit_idx = c_IDX_W'(k);
            end
        end
    end

    // Segment patterns are g..a, active-low.
    always_comb begin
        w_nibble  = 4'h0;
        w_dec_err = 1'b0;
        case (r_seg_s2)
            7'b1000000: w_nibble = 4'h0;
            7'b1111001: w_nibble = 4'h1;
            7'b0100100: w_nibble = 4'h2;
            7'b0110000: w_nibble = 4'h3;
            7'b0011001: w_nibble = 4'h4;
            7'b0010010: w_nibble = 4'h5;
            7'b0000010: w_nibble = 4'h6;
            7'b1111000: w_nibble = 4'h7;
            7'b0000000: w_nibble = 4'h8;
            7'b0010000: w_nibble = 4'h9;
            7'b0001000: w_nibble = 4'hA;
            7'b0000011: w_nibble = 4'hB;
            7'b1000110: w_nibble = 4'hC;
            7'b0100001: w_nibble = 4'hD;
            7'b0000110: w_nibble = 4'hE;
            7'b0001110: w_nibble = 4'hF;
            default:    w_dec_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_stab_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_stab_cnt <= w_stab_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_stab_cnt_next = r_stab_cnt;
        w_capture       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stab_cnt_next = '0;
                if (w_an_onehot) begin
                    w_state_next = S_TRACK;
                end
            end
            S_TRACK: begin
                if (w_changed) begin
                    w_stab_cnt_next = '0;
                    w_state_next    = w_an_onehot ? S_TRACK : S_IDLE;
                end else if (r_stab_cnt == c_CNT_LAST) begin
                    w_capture       = 1'b1;
                    w_stab_cnt_next = '0;
                    w_state_next    = S_HELD;
                end else begin
                    w_stab_cnt_next = r_stab_cnt + CNT_W'(1);
                end
            end
            S_HELD: begin
                // A dwell is captured once; only a bus change re-arms tracking.
                if (w_changed) begin
                    w_stab_cnt_next = '0;
                    w_state_next    = w_an_onehot ? S_TRACK : S_IDLE;
                end
            end
            default: begin
                w_stab_cnt_next = '0;
                w_state_next    = S_IDLE;
            end
        endcase
    end

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit_we
            assign w_we[k] = w_capture && (w_digit_idx == c_IDX_W'(k));
        end
    endgenerate

    assign w_frame_done = &r_seen;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seen        <= '0;
            r_shadow_data <= '0;
            r_shadow_err  <= '0;
            frame_data    <= '0;
            frame_err     <= '0;
            frame_valid   <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            r_seen <= (w_frame_done ? '0 : r_seen) | w_we;
            for (int k = 0; k < DIGITS; k++) begin
                if (w_we[k]) begin
                    r_shadow_data[4*k +: 4] <= w_nibble;
                    r_shadow_err[k]         <= w_dec_err;
                end
            end
            // A completing frame wins over acceptance; overrun only if the old one was lost.
            overrun <= w_frame_done && frame_valid && !frame_ready;
            if (w_frame_done) begin
                frame_data  <= r_shadow_data;
                frame_err   <= r_shadow_err;
                frame_valid <= 1'b1;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
